// File: rtl/rr_req_gnt_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Package : arb_pkg
// Shared state encoding and defaults for the round-robin arbiter.
// Rev 1.0
// ============================================================
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;

  // Modulo-n wrap for an index that is known to be below 2*n.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_req_gnt_arbiter_pick.sv
`default_nettype none
// ============================================================
// Module : rr_pick
// Cyclic first-one search over req starting at ptr.
// Rev 1.0
// ============================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  src_idx;
  int               off;

  always_comb begin
    rot     = '0;
    src_idx = '0;
    off     = 0;
    for (int j = 0; j < N_REQ; j++) begin
      src_idx = ID_W'(wrap_idx(int'(ptr) + j, N_REQ));
      rot[j]  = req[src_idx];
    end
    // Descending scan so the lowest set offset wins.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    found  = |rot;
    winner = ID_W'(wrap_idx(int'(ptr) + off, N_REQ));
  end

endmodule
`default_nettype wire

// File: rtl/rr_req_gnt_arbiter.sv
`default_nettype none
// ============================================================
// Module : rr_req_gnt_arbiter
// Round-robin req/gnt arbiter with registered grant and hold timeout.
// Rev 1.0
// ============================================================
module rr_req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;

  logic [ID_W-1:0]  pick_win;
  logic             pick_found;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_win),
    .found  (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;

    // In BUSY the holder's own req bit is low whenever we re-arbitrate,
    // so a shared pick path serves IDLE, handover and FORCE alike.
    if (state_q == IDLE || state_q == FORCE || !req[gnt_id_q]) begin
      if (pick_found) begin
        gnt_d           = '0;
        gnt_d[pick_win] = 1'b1;
        gnt_id_d        = pick_win;
        ptr_d           = (pick_win == ID_W'(N_REQ - 1)) ? '0 : pick_win + 1'b1;
        hcnt_d          = HC_W'(1);
        state_d         = BUSY;
      end else begin
        gnt_d    = '0;
        gnt_id_d = '0;
        hcnt_d   = '0;
        state_d  = IDLE;
      end
    end else if (MAX_HOLD != 0 && hcnt_q == HC_W'(MAX_HOLD)) begin
      gnt_d     = '0;
      gnt_id_d  = '0;
      hcnt_d    = '0;
      timeout_d = 1'b1;
      state_d   = FORCE;
    end else if (MAX_HOLD != 0) begin
      hcnt_d = hcnt_q + HC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (reset) gnt_valid == |gnt);
  a_req_gnt: assert property (@(posedge clk) disable iff (reset)
                              (!gnt_valid && |req) |=> gnt_valid);
  a_to_gap: assert property (@(posedge clk) disable iff (reset) timeout |-> !gnt_valid);

  for (genvar i = 0; i < N_REQ; i++) begin : g_gnt_past
    a_gnt_req: assert property (@(posedge clk) disable iff (reset) gnt[i] |-> $past(req[i]));
  end

  if (MAX_HOLD != 0) begin : g_hold_chk
    // Length of the current run of one unchanged grant, saturating just past the limit.
    logic [HC_W:0]    run_q, run_d;
    logic [N_REQ-1:0] prev_gnt_q;

    always_comb begin
      run_d = '0;
      if (gnt_q != '0 && gnt_q == prev_gnt_q)
        run_d = (int'(run_q) > MAX_HOLD) ? run_q : run_q + (HC_W+1)'(1);
      else if (gnt_q != '0)
        run_d = (HC_W+1)'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        run_q      <= '0;
        prev_gnt_q <= '0;
      end else begin
        run_q      <= run_d;
        prev_gnt_q <= gnt_q;
      end
    end

    a_max_hold: assert property (@(posedge clk) disable iff (reset) int'(run_q) <= MAX_HOLD);
  end
`endif

endmodule
`default_nettype wire
